mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high reset
  req_valid  in  1  execute stage presents an MDU op; held with op and operands until req_ready
  req_op  in  mdu_op_t(3)  NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO
  req_a, req_b  in  32  rs, rt operands
  req_ready  out  1  op completes this cycle; execute stall = req_valid & ~req_ready
  flush  in  1  abort current op, no architectural effect
  hi, lo  out  32  architectural HI/LO; MFHI/MFLO read these directly
  mul_valid, div_valid  out  1  launch/hold request to multiplier/divider
  mul_a, mul_b, div_a, div_b  out  32  unsigned operands to units
  mul_done, div_done  in  1  unit result valid this cycle
  mul_c  in  64  {hi,lo} product
  div_c  in  64  {remainder, quotient}
REQ-002 SHALL have no parameters.

Function
REQ-003 States: IDLE, MUL_WAIT, DIV_WAIT, FIX, DRAIN.
REQ-004 IDLE, req_valid, NOP: req_ready=1 combinationally; no state change.
REQ-005 IDLE, req_valid, MTHI/MTLO: req_ready=1 combinationally; req_a written to hi/lo at that edge.
REQ-006 IDLE, req_valid, DIV/DIVU with req_b==0: req_ready=1 combinationally; hi/lo unchanged; no unit launched.
REQ-007 IDLE, req_valid, MULT/MULTU/DIV/DIVU (b!=0): req_ready=0; register operand magnitudes, sign_a, sign_b and op; go to MUL_WAIT or DIV_WAIT.
REQ-008 Signed ops: magnitude = two's-complement negate if bit31 set; 0x80000000 yields 0x80000000 unsigned. Unsigned ops: operands pass unchanged; signs forced 0.
REQ-009 MUL_WAIT/DIV_WAIT: the matching valid=1 with registered operands, held stable; done is sampled only in these states. On done=1, capture the 64-bit result and go to FIX; valid drops the following cycle.
REQ-010 FIX: product negated (64-bit) if sign_a^sign_b; quotient negated if sign_a^sign_b; remainder negated if sign_a. {hi,lo} <= product, or hi <= remainder, lo <= quotient, at FIX edge. req_ready=1 in FIX; next state IDLE.
REQ-011 MULT latency: accept at T, req_ready at T+3 for a 1-cycle-done multiplier. Divider latency = div_done cycle + 1.
REQ-012 flush in MUL_WAIT/DIV_WAIT: go to DRAIN; valid held until unit done, then IDLE; no hi/lo write. req_ready=0 in DRAIN.
REQ-013 flush in FIX: no hi/lo write; go to IDLE. flush in IDLE: request ignored, req_ready=0, no write.
REQ-014 Overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no exception.
REQ-015 Only one unit valid at a time; mul_valid and div_valid never both 1.

Reset
REQ-016 reset (async, active-high) SHALL force IDLE, hi=lo=0, mul_valid=div_valid=0, captured-result and operand registers 0; mid-operation reset discards the op.
REQ-017 reset has priority over flush and every request.

Structure
REQ-018 mdu_op_t and the state enum SHALL live in shared package mdu_pkg; i32/i64 come from the common package.
REQ-019 Sign correction SHALL be one combinational sub-module, mdu_signfix (magnitudes in; corrected hi/lo out).

Verification
REQ-020 MULT a=0xFFFFFFFD, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; req_ready at T+3.
REQ-021 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-022 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-023 MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> each req_ready same cycle; then DIV x/0 -> hi/lo unchanged, req_ready same cycle.
REQ-024 DIV 100/7 with flush 3 cycles after accept -> DRAIN until div_done, hi/lo unchanged; then MULT 6x7 -> lo=42, hi=0.
REQ-025 Async reset asserted mid-MUL_WAIT between clock edges -> immediately IDLE, hi=lo=0, mul_valid=0.

Source files
------------

// File: rtl/common_pkg.sv
// Shared scalar types for the core.
package common_pkg;
    typedef logic [31:0] i32;
    typedef logic [63:0] i64;
endpackage

// File: rtl/mdu_pkg.sv
// MDU opcodes, controller states and operand helpers.
package mdu_pkg;
    import common_pkg::*;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MTHI,
        OP_MTLO
    } mdu_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_WAIT,
        S_FIX,
        S_DRAIN
    } mdu_state_t;

    function automatic logic is_signed_op(mdu_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    function automatic i32 magnitude(i32 x, logic sgn);
        return (sgn && x[31]) ? -x : x;
    endfunction
endpackage

// File: rtl/mdu_signfix.sv
// Applies operand signs to unsigned unit results to form HI/LO.
module mdu_signfix
    import common_pkg::*;
(
    input  logic        is_div,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic [63:0] res,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    i64   prod;
    i32   quo;
    i32   rem;
    logic neg;

    always_comb begin
        neg  = sign_a ^ sign_b;
        prod = neg ? -res : res;
        quo  = res[31:0];
        rem  = res[63:32];
        if (neg)
            quo = -quo;
        // remainder takes the dividend's sign
        if (sign_a)
            rem = -rem;
        hi = is_div ? rem : prod[63:32];
        lo = is_div ? quo : prod[31:0];
    end
endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: sequences the external units and owns HI/LO.
module mdu_ctrl
    import common_pkg::*;
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  mdu_op_t     req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_valid,
    output logic        div_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        mul_done,
    input  logic        div_done,
    input  logic [63:0] mul_c,
    input  logic [63:0] div_c
);
    mdu_state_t state, state_n;
    mdu_op_t    op_q;
    logic       sa_q, sb_q;
    i32         ma_q, mb_q;
    i64         res_q;
    i32         hi_q, lo_q;

    logic accept, capture, wr_hi, wr_lo;
    i32   hi_d, lo_d;
    i32   fix_hi, fix_lo;
    logic is_div_q, sgn_in;

    assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign sgn_in   = is_signed_op(req_op);

    mdu_signfix u_signfix (
        .is_div (is_div_q),
        .sign_a (sa_q),
        .sign_b (sb_q),
        .res    (res_q),
        .hi     (fix_hi),
        .lo     (fix_lo)
    );

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        mul_valid = 1'b0;
        div_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        hi_d      = fix_hi;
        lo_d      = fix_lo;
        case (state)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    case (req_op)
                        OP_MTHI: begin
                            req_ready = 1'b1;
                            wr_hi     = 1'b1;
                            hi_d      = req_a;
                        end
                        OP_MTLO: begin
                            req_ready = 1'b1;
                            wr_lo     = 1'b1;
                            lo_d      = req_a;
                        end
                        OP_MULT, OP_MULTU: begin
                            accept  = 1'b1;
                            state_n = S_MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (req_b == '0) begin
                                req_ready = 1'b1;
                            end else begin
                                accept  = 1'b1;
                                state_n = S_DIV_WAIT;
                            end
                        end
                        default: req_ready = 1'b1;
                    endcase
                end
            end
            S_MUL_WAIT: begin
                mul_valid = 1'b1;
                if (flush)
                    state_n = mul_done ? S_IDLE : S_DRAIN;
                else if (mul_done) begin
                    capture = 1'b1;
                    state_n = S_FIX;
                end
            end
            S_DIV_WAIT: begin
                div_valid = 1'b1;
                if (flush)
                    state_n = div_done ? S_IDLE : S_DRAIN;
                else if (div_done) begin
                    capture = 1'b1;
                    state_n = S_FIX;
                end
            end
            S_FIX: begin
                state_n = S_IDLE;
                if (!flush) begin
                    req_ready = 1'b1;
                    wr_hi     = 1'b1;
                    wr_lo     = 1'b1;
                end
            end
            S_DRAIN: begin
                // unit must finish before it can take a new launch
                mul_valid = !is_div_q;
                div_valid = is_div_q;
                if (is_div_q ? div_done : mul_done)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= OP_NOP;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            ma_q  <= '0;
            mb_q  <= '0;
            res_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q <= req_op;
                sa_q <= sgn_in & req_a[31];
                sb_q <= sgn_in & req_b[31];
                ma_q <= magnitude(req_a, sgn_in);
                mb_q <= magnitude(req_b, sgn_in);
            end
            if (capture)
                res_q <= is_div_q ? div_c : mul_c;
            if (wr_hi)
                hi_q <= hi_d;
            if (wr_lo)
                lo_q <= lo_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign mul_a = ma_q;
    assign mul_b = mb_q;
    assign div_a = ma_q;
    assign div_b = mb_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl with behavioural multiplier/divider models.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    mdu_op_t     req_op;
    logic [31:0] req_a, req_b;
    logic        req_ready;
    logic        flush;
    logic [31:0] hi, lo;
    logic        mul_valid, div_valid;
    logic [31:0] mul_a, mul_b, div_a, div_b;
    logic        mul_done, div_done;
    logic [63:0] mul_c, div_c;

    int tests = 0;
    int fails = 0;
    int mul_lat = 1;
    int div_lat = 4;
    int mcnt = 0;
    int dcnt = 0;
    bit both_seen = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a, b, ehi, elo;
        int          lat;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .flush     (flush),
        .hi        (hi),
        .lo        (lo),
        .mul_valid (mul_valid),
        .div_valid (div_valid),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .div_a     (div_a),
        .div_b     (div_b),
        .mul_done  (mul_done),
        .div_done  (div_done),
        .mul_c     (mul_c),
        .div_c     (div_c)
    );

    // unit models: done rises once valid has been seen for lat+1 cycles
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            mul_done = 0; div_done = 0; mcnt = 0; dcnt = 0;
            mul_c = '0; div_c = '0;
        end else begin
            if (mul_valid && div_valid)
                both_seen = 1;
            if (mul_done) begin
                mul_done = 0; mcnt = 0;
            end else if (mul_valid) begin
                mcnt++;
                if (mcnt > mul_lat) begin
                    mul_done = 1;
                    mul_c = {32'b0, mul_a} * {32'b0, mul_b};
                end
            end
            if (div_done) begin
                div_done = 0; dcnt = 0;
            end else if (div_valid) begin
                dcnt++;
                if (dcnt > div_lat) begin
                    div_done = 1;
                    div_c = (div_b == 0) ? 64'b0 : {div_a % div_b, div_a / div_b};
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int elat, input string name);
        int cyc;
        bit done;
        logic [63:0] e;
        exp_q.push_back({ehi, elo});
        @(negedge clk);
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        cyc = 0; done = 0;
        while (!done && cyc < 60) begin
            #1;
            if (req_ready) done = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({name, " done"}, 64'(done), 64'd1);
        if (elat >= 0)
            chk({name, " lat"}, 64'(cyc), 64'(elat));
        @(negedge clk);
        req_valid = 0; req_op = OP_NOP;
        #1;
        e = exp_q.pop_front();
        chk({name, " hilo"}, {hi, lo}, e);
    endtask

    initial begin
        logic [31:0] ra, rb, h0, l0;
        logic [63:0] p;
        int sa, sb, q, r, n;

        tbl[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 3};
        tbl[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};
        tbl[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 6};
        tbl[3]  = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        6};
        tbl[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 6};
        tbl[5]  = '{OP_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'h80000000, 0};
        tbl[6]  = '{OP_MTLO,  32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
        tbl[7]  = '{OP_DIV,   32'd5,        32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
        tbl[8]  = '{OP_DIVU,  32'd5,        32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
        tbl[9]  = '{OP_NOP,   32'd1,        32'd1,        32'h12345678, 32'h9ABCDEF0, 0};
        tbl[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3};
        tbl[11] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 6};
        tbl[12] = '{OP_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 3};
        tbl[13] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        6};

        reset = 1; req_valid = 0; req_op = OP_NOP; req_a = 0; req_b = 0; flush = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        chk("reset hilo", {hi, lo}, 64'd0);
        chk("reset valids", {62'd0, mul_valid, div_valid}, 64'd0);

        foreach (tbl[i])
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo,
                  tbl[i].lat, $sformatf("vec%0d", i));

        // flush while idle suppresses the write and the handshake
        h0 = hi; l0 = lo;
        @(negedge clk);
        req_valid = 1; req_op = OP_MTHI; req_a = 32'hDEADBEEF; flush = 1;
        #1;
        chk("idle flush ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        req_valid = 0; flush = 0;
        #1;
        chk("idle flush hilo", {hi, lo}, {h0, l0});

        // flush three cycles into a divide, then drain
        @(negedge clk);
        req_valid = 1; req_op = OP_DIV; req_a = 32'd100; req_b = 32'd7;
        #1;
        chk("flush accept ready", 64'(req_ready), 64'd0);
        repeat (3) @(negedge clk);
        flush = 1; req_valid = 0;
        @(negedge clk);
        flush = 0;
        #1;
        chk("drain div_valid", 64'(div_valid), 64'd1);
        chk("drain ready", 64'(req_ready), 64'd0);
        n = 0;
        while (div_valid && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain ends", 64'(div_valid), 64'd0);
        chk("drain hilo", {hi, lo}, {h0, l0});
        do_op(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 3, "post flush mult");

        // compare random ops against native arithmetic
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            rb = $urandom_range(1000, 2);
            if ($urandom_range(1, 0) == 1) rb = -rb;
            sa = $signed(ra);
            sb = $signed(rb);
            case (k % 4)
                0: begin
                    p = 64'(longint'(sa) * longint'(sb));
                    do_op(OP_MULT, ra, rb, p[63:32], p[31:0], 3, $sformatf("rnd mult%0d", k));
                end
                1: begin
                    p = {32'b0, ra} * {32'b0, rb};
                    do_op(OP_MULTU, ra, rb, p[63:32], p[31:0], 3, $sformatf("rnd multu%0d", k));
                end
                2: begin
                    q = sa / sb;
                    r = sa % sb;
                    do_op(OP_DIV, ra, rb, r, q, 6, $sformatf("rnd div%0d", k));
                end
                default: begin
                    do_op(OP_DIVU, ra, rb, ra % rb, ra / rb, 6, $sformatf("rnd divu%0d", k));
                end
            endcase
        end

        // async reset in the middle of a multiply wait
        mul_lat = 20;
        @(negedge clk);
        req_valid = 1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd4;
        repeat (2) @(negedge clk);
        #1;
        chk("pre-reset mul_valid", 64'(mul_valid), 64'd1);
        #2;
        req_valid = 0;
        reset = 1;
        #1;
        chk("async reset mul_valid", 64'(mul_valid), 64'd0);
        chk("async reset hilo", {hi, lo}, 64'd0);
        chk("async reset ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        reset = 0;
        mul_lat = 1;
        do_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 3, "post reset multu");

        chk("unit exclusivity", 64'(both_seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
